// File: rtl/bus_demux_scheduler.sv
// bus_demux_scheduler: single-word stream front-end for Bus_Demux.
// Holds one accepted word and presents it on Y/SEL with a one-hot valid to
// one of four consumer channels. The channel comes from the tag (directed)
// or from a burst-limited round-robin pointer.
module bus_demux_scheduler #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mode_i,
  input  logic [BUS_WIDTH-1:0] in_data_i,
  input  logic [1:0]           in_dest_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [BUS_WIDTH-1:0] y_o,
  output logic [1:0]           sel_o,
  output logic [3:0]           out_valid_o,
  input  logic [3:0]           out_ready_i,
  output logic [15:0]          sent_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   y_q, y_d;
  logic [1:0]             sel_q, sel_d;
  logic [3:0]             out_valid_q, out_valid_d;
  logic [15:0]            sent_cnt_q, sent_cnt_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [7:0]             burst_q, burst_d;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   deliver_s;

  // Handshake decode: in HOLD the source may only refill when the held word
  // leaves on this same edge, so ready follows the selected channel's ready.
  always_comb begin
    in_ready_s = 1'b0;
    deliver_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        deliver_s  = 1'b0;
      end
      ST_HOLD: begin
        in_ready_s = out_ready_i[sel_q];
        deliver_s  = out_ready_i[sel_q];
      end
      default: begin
        in_ready_s = 1'b0;
        deliver_s  = 1'b0;
      end
    endcase
    accept_s = in_valid_i & in_ready_s;
  end

  // Next-state computation for the FSM, held word, scheduler and counter.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    burst_d     = burst_q;
    sent_cnt_d  = sent_cnt_q;
    out_valid_d = 4'b0000;

    if (accept_s) begin
      state_d = ST_HOLD;
      y_d     = in_data_i;
      if (mode_i) begin
        sel_d = rr_ptr_q;
        if ((burst_q + 8'd1) >= MAX_BURST_C) begin
          burst_d  = 8'd0;
          rr_ptr_d = rr_ptr_q + 2'd1;
        end else begin
          burst_d  = burst_q + 8'd1;
          rr_ptr_d = rr_ptr_q;
        end
      end else begin
        sel_d    = in_dest_i;
        burst_d  = 8'd0;
        rr_ptr_d = rr_ptr_q;
      end
    end else if (deliver_s) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    if (deliver_s && (sent_cnt_q != 16'hFFFF)) begin
      sent_cnt_d = sent_cnt_q + 16'd1;
    end else begin
      sent_cnt_d = sent_cnt_q;
    end

    if (state_d == ST_HOLD) begin
      out_valid_d = 4'b0001 << sel_d;
    end else begin
      out_valid_d = 4'b0000;
    end
  end

  // FSM state and registered outputs; async reset discards any held word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      sel_q       <= 2'd0;
      out_valid_q <= 4'b0000;
      sent_cnt_q  <= 16'd0;
      rr_ptr_q    <= 2'd0;
      burst_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      sent_cnt_q  <= sent_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_q     <= burst_d;
    end
  end

  assign in_ready_o  = in_ready_s;
  assign y_o         = y_q;
  assign sel_o       = sel_q;
  assign out_valid_o = out_valid_q;
  assign sent_cnt_o  = sent_cnt_q;

endmodule

// File: tb/tb_bus_demux_scheduler.sv
// Directed self-checking bench for bus_demux_scheduler.
module tb_bus_demux_scheduler;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  y;
  logic [1:0]  sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bus_demux_scheduler #(.BUS_WIDTH(8), .MAX_BURST(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode),
    .in_data_i  (in_data),
    .in_dest_i  (in_dest),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .y_o        (y),
    .sel_o      (sel),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sent_cnt_o (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode-switch schedule: mode, dest, expected SEL
  logic       sw_mode [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] sw_dest [0:7] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [1:0] sw_sel  [0:7] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_data   = 8'd0;
    in_dest   = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: one word per channel, back to back
    mode = 1'b0; in_data = 8'd123; in_dest = 2'd0; in_valid = 1'b1; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dir_sel", {30'd0, sel}, i);
      chk("dir_ov", {28'd0, out_valid}, 32'd1 << i);
      chk("dir_y", {24'd0, y}, 32'd123);
      chk("dir_ready", {31'd0, in_ready}, 32'd1);
      if (i < 3) in_dest = 2'(i + 1);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("dir_idle_ov", {28'd0, out_valid}, 32'd0);
    chk("dir_cnt", {16'd0, sent_cnt}, 32'd4);

    // Backpressure on channel 2; source keeps offering a different word
    in_dest = 2'd2; in_data = 8'h5A; in_valid = 1'b1; out_ready = 4'h0;
    @(negedge clk);
    in_data = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov", {28'd0, out_valid}, 32'h4);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_y", {24'd0, y}, 32'h5A);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 4'b0100;
    #1;
    chk("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_cnt", {16'd0, sent_cnt}, 32'd5);
    chk("bp_idle_ov", {28'd0, out_valid}, 32'd0);
    chk("idle_y_kept", {24'd0, y}, 32'h5A);
    chk("idle_sel_kept", {30'd0, sel}, 32'd2);

    // Ready on every channel except the selected one
    in_dest = 2'd1; in_data = 8'h33; in_valid = 1'b1; out_ready = 4'b1101;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wr_ov", {28'd0, out_valid}, 32'h2);
      chk("wr_ready", {31'd0, in_ready}, 32'd0);
      chk("wr_cnt", {16'd0, sent_cnt}, 32'd5);
      @(negedge clk);
    end
    out_ready = 4'b0010;
    @(negedge clk);
    chk("wr_cnt_after", {16'd0, sent_cnt}, 32'd6);

    // Asynchronous reset while holding a word
    in_dest = 2'd2; in_data = 8'h77; in_valid = 1'b1; out_ready = 4'h0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_hold_ov", {28'd0, out_valid}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", {28'd0, out_valid}, 32'd0);
    chk("ar_y", {24'd0, y}, 32'd0);
    chk("ar_sel", {30'd0, sel}, 32'd0);
    chk("ar_cnt", {16'd0, sent_cnt}, 32'd0);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin, 17 words
    mode = 1'b1; in_dest = 2'd3; in_data = 8'd1; in_valid = 1'b1; out_ready = 4'hF;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      chk("rr_y", {24'd0, y}, i);
      chk("rr_sel", {30'd0, sel}, ((i - 1) / 4) % 4);
      if (i < 17) in_data = 8'(i + 1);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("rr_cnt", {16'd0, sent_cnt}, 32'd17);

    // Mode switch mid-burst; pointer is at 0 with one word of burst used
    in_data = 8'hC0; in_valid = 1'b1; mode = sw_mode[0]; in_dest = sw_dest[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("sw_sel", {30'd0, sel}, {30'd0, sw_sel[i]});
      if (i < 7) begin
        mode = sw_mode[i + 1]; in_dest = sw_dest[i + 1]; in_data = 8'(8'hC1 + i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("sw_cnt", {16'd0, sent_cnt}, 32'd25);

    // Stream to the counter's ceiling
    mode = 1'b0; in_dest = 2'd0; in_valid = 1'b1; out_ready = 4'hF;
    repeat (65534 - 25) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_pre", {16'd0, sent_cnt}, 32'hFFFE);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_hold", {16'd0, sent_cnt}, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
